// File: rtl/uart_frame_rx.sv
// ---------------------------------------------------------------------------
// uart_frame_rx
//   Byte-stream framer between uart_rx and the LeNet input-image buffer.
//   Hunts for the two-byte sync word, streams N_PIX pixel bytes into the
//   buffer at sequential addresses, then checks the 8-bit additive checksum.
//   An inter-byte timeout or a UART framing error drops the frame and
//   returns to sync hunting.
//
//   Frame on the wire: SYNC0, SYNC1, N_PIX pixel bytes, CSUM
//   (CSUM = sum of the pixel bytes mod 256; sync bytes are excluded).
//
// Ports
//   clk200M    in   system clock
//   rst        in   asynchronous reset, active-high
//   rx_data    in   received byte, qualified by rx_valid
//   rx_valid   in   one-cycle strobe per received byte
//   rx_err     in   one-cycle framing-error strobe; overrides rx_valid
//   wr_en      out  image-buffer write strobe (one cycle after the byte)
//   wr_addr    out  image-buffer write address
//   wr_data    out  image-buffer write data
//   busy       out  high whenever the framer is not in IDLE
//   frame_done out  one-cycle pulse: frame complete, checksum good
//   frame_err  out  one-cycle pulse: bad checksum, timeout, or rx_err abort
// ---------------------------------------------------------------------------
module uart_frame_rx #(
    parameter int         N_PIX       = 1024,
    parameter int         ADDR_W      = 10,
    parameter logic [7:0] SYNC0       = 8'hA5,
    parameter logic [7:0] SYNC1       = 8'h5A,
    parameter int         TIMEOUT_CYC = 4000
) (
    input  logic              clk200M,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SY1  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_CSUM = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIX - 1);

    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    // The abort is registered, so it is taken on the cycle whose count would
    // reach TIMEOUT_CYC-1; frame_err then lands exactly TIMEOUT_CYC cycles
    // after the last strobe, and a byte arriving in that same cycle still wins.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pix_cnt;
    logic [7:0]        csum;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              in_frame;

    // Aborts only report an error once pixel data has started.
    assign in_frame = (state == ST_DATA) || (state == ST_CSUM);

    // busy is decoded from state so it falls in the same cycle the
    // registered done/err pulse rises.
    assign busy = (state != ST_IDLE);

    // NOTE: every register here is sequential state and uses non-blocking
    // assignment so all flops update together from pre-edge values.
    always_ff @(posedge clk200M or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pix_cnt    <= '0;
            csum       <= '0;
            tmo_cnt    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (rx_err) begin
                // Framing error: drop the byte and resync.
                frame_err <= in_frame;
                state     <= ST_IDLE;
                tmo_cnt   <= '0;
            end else if (rx_valid) begin
                tmo_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (rx_data == SYNC0) state <= ST_SY1;
                    end
                    ST_SY1: begin
                        if (rx_data == SYNC1) begin
                            state   <= ST_DATA;
                            pix_cnt <= '0;
                            csum    <= '0;
                        end else if (rx_data != SYNC0) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        wr_en   <= 1'b1;
                        wr_addr <= pix_cnt;
                        wr_data <= rx_data;
                        csum    <= csum + rx_data;
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == LAST_PIX) state <= ST_CSUM;
                    end
                    default: begin
                        if (rx_data == csum) frame_done <= 1'b1;
                        else                 frame_err  <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end else if (state != ST_IDLE) begin
                if (tmo_cnt == TMO_LAST) begin
                    frame_err <= in_frame;
                    state     <= ST_IDLE;
                    tmo_cnt   <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_rx
//   Directed and randomized frames against uart_frame_rx. Expected writes,
//   pulse counts and pulse timing come from frame-level reasoning (which
//   pixels were sent, their sum mod 256, cycle distances), not from a copy
//   of the DUT state machine.
// ---------------------------------------------------------------------------
module tb_uart_frame_rx;

    localparam int N_PIX  = 1024;
    localparam int ADDR_W = 10;
    localparam int TC     = 4000;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_err;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              frame_done;
    logic              frame_err;

    uart_frame_rx #(
        .N_PIX(N_PIX), .ADDR_W(ADDR_W), .SYNC0(8'hA5), .SYNC1(8'h5A), .TIMEOUT_CYC(TC)
    ) dut (
        .clk200M(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int done_cyc = -1, err_cyc = -1, last_strobe = 0;
    int got_addr[$];
    int got_data[$];
    logic [7:0] pix [N_PIX];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(int'(wr_data));
        end
        if (frame_done) begin done_cnt++; done_cyc = cyc; end
        if (frame_err)  begin err_cnt++;  err_cyc  = cyc; end
        if (frame_done && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one strobe cycle, returns gap cycles later.
    task automatic send_byte(input logic [7:0] b, input bit err, input int gap);
        rx_data     = b;
        rx_valid    = 1'b1;
        rx_err      = err;
        last_strobe = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    function automatic int pick_gap(input bit rnd);
        return rnd ? int'($urandom_range(1, 3)) : 2;
    endfunction

    // Sends sync + pixels (+ checksum). err_at >= 0 aborts with rx_err on that pixel.
    task automatic send_frame(input logic [7:0] csum_b, input int err_at, input bit rnd);
        send_byte(8'hA5, 1'b0, pick_gap(rnd));
        send_byte(8'h5A, 1'b0, pick_gap(rnd));
        for (int i = 0; i < N_PIX; i++) begin
            if (i == err_at) begin
                send_byte(pix[i], 1'b1, pick_gap(rnd));
                return;
            end
            send_byte(pix[i], 1'b0, pick_gap(rnd));
        end
        send_byte(csum_b, 1'b0, 1);
    endtask

    function automatic logic [7:0] model_csum();
        int s = 0;
        for (int i = 0; i < N_PIX; i++) s += int'(pix[i]);
        return 8'(s % 256);
    endfunction

    // Compares captured writes/pulses against the frame-level expectation.
    task automatic check_frame(input string pfx, input int exp_n, input int d0, input int e0,
                               input int exp_d, input int exp_e);
        int mism = 0;
        repeat (3) @(negedge clk);
        chk({pfx, "_nwr"}, got_addr.size(), exp_n);
        for (int i = 0; i < got_addr.size(); i++)
            if (got_addr[i] != i || i >= N_PIX || got_data[i] != int'(pix[i % N_PIX])) mism++;
        chk({pfx, "_wr_mism"}, mism, 0);
        chk({pfx, "_done"}, done_cnt - d0, exp_d);
        chk({pfx, "_err"}, err_cnt - e0, exp_e);
        chk({pfx, "_busy"}, int'(busy), 0);
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic chk_outs_zero(input string pfx);
        chk({pfx, "_wr_en"}, int'(wr_en), 0);
        chk({pfx, "_wr_addr"}, int'(wr_addr), 0);
        chk({pfx, "_wr_data"}, int'(wr_data), 0);
        chk({pfx, "_busy"}, int'(busy), 0);
        chk({pfx, "_done"}, int'(frame_done), 0);
        chk({pfx, "_err"}, int'(frame_err), 0);
    endtask

    initial begin
        int d0, e0, c0, kind, pos;
        logic [7:0] cs;
        rst = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_outs_zero("rst_init");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: reset in the middle of pixel data.
        for (int i = 0; i < N_PIX; i++) pix[i] = 8'($urandom);
        send_byte(8'hA5, 1'b0, 2);
        send_byte(8'h5A, 1'b0, 2);
        for (int i = 0; i < 20; i++) send_byte(pix[i], 1'b0, 2);
        chk("t1_busy_mid", int'(busy), 1);
        chk("t1_nwr_mid", got_addr.size(), 20);
        rst = 1'b1;
        @(negedge clk);
        chk_outs_zero("t1_rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_no_pulse", done_cnt + err_cnt, 0);
        got_addr.delete();
        got_data.delete();

        // T2: ramp frame, checksum 00 is correct.
        for (int i = 0; i < N_PIX; i++) pix[i] = 8'(i);
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h00, -1, 1'b0);
        c0 = last_strobe;
        check_frame("t2", N_PIX, d0, e0, 1, 0);
        chk("t2_done_lat", done_cyc - c0, 1);

        // T3: same frame, wrong checksum.
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h01, -1, 1'b0);
        c0 = last_strobe;
        check_frame("t3", N_PIX, d0, e0, 0, 1);
        chk("t3_err_lat", err_cyc - c0, 1);

        // T4: noise and a repeated SYNC0 before the real sync.
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h00, 1'b0, 2);
        chk("t4_idle_after_00", int'(busy), 0);
        send_byte(8'hA5, 1'b0, 2);
        chk("t4_busy_sy1", int'(busy), 1);
        send_frame(model_csum(), -1, 1'b0);
        check_frame("t4", N_PIX, d0, e0, 1, 0);
        send_byte(8'hA5, 1'b0, 2);
        send_byte(8'h33, 1'b0, 3);
        chk("t4_a5_33_idle", int'(busy), 0);
        // rx_err during sync hunt: no pulse, back to IDLE, lone 5A ignored.
        send_byte(8'hA5, 1'b0, 2);
        send_byte(8'h5A, 1'b1, 2);
        send_byte(8'h5A, 1'b0, 2);
        send_byte(8'h11, 1'b0, 2);
        check_frame("t4_sy_err", 0, d0 + 1, e0, 0, 0);

        // T5a: silence after 100 pixels.
        for (int i = 0; i < N_PIX; i++) pix[i] = 8'($urandom);
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA5, 1'b0, 2);
        send_byte(8'h5A, 1'b0, 2);
        for (int i = 0; i < 100; i++) send_byte(pix[i], 1'b0, 2);
        c0 = last_strobe;
        repeat (TC - 10) @(negedge clk);
        chk("t5_early_err", err_cnt - e0, 0);
        repeat (30) @(negedge clk);
        chk("t5_tmo_lat", err_cyc - c0, TC);
        check_frame("t5", 100, d0, e0, 0, 1);

        // T5b: a byte exactly at terminal count keeps the frame alive.
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA5, 1'b0, 2);
        send_byte(8'h5A, 1'b0, 2);
        for (int i = 0; i < 9; i++) send_byte(pix[i], 1'b0, 2);
        send_byte(pix[9], 1'b0, TC - 1);
        send_byte(pix[10], 1'b0, 2);
        chk("t5_tc_no_abort", err_cnt - e0, 0);
        chk("t5_tc_busy", int'(busy), 1);
        c0 = last_strobe;
        repeat (TC + 20) @(negedge clk);
        chk("t5_tc_tmo_lat", err_cyc - c0, TC);
        check_frame("t5_tc", 11, d0, e0, 0, 1);

        // SY1 timeout: no error pulse.
        e0 = err_cnt;
        send_byte(8'hA5, 1'b0, TC + 20);
        chk("t5_sy1_tmo_busy", int'(busy), 0);
        chk("t5_sy1_tmo_err", err_cnt - e0, 0);

        // T6: rx_err on pixel 500, then a clean frame.
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h00, 500, 1'b0);
        check_frame("t6_abort", 500, d0, e0, 0, 1);
        d0 = done_cnt; e0 = err_cnt;
        send_frame(model_csum(), -1, 1'b1);
        check_frame("t6_next", N_PIX, d0, e0, 1, 0);

        // Randomized frames: good / bad checksum / rx_err abort, random spacing.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N_PIX; i++) pix[i] = 8'($urandom);
            for (int j = 0; j < int'($urandom_range(0, 4)); j++)
                send_byte(8'($urandom_range(0, 127)), 1'b0, 2);
            kind = int'($urandom_range(0, 2));
            pos  = int'($urandom_range(0, N_PIX - 1));
            cs   = model_csum();
            d0 = done_cnt; e0 = err_cnt;
            if (kind == 0) begin
                send_frame(cs, -1, 1'b1);
                check_frame($sformatf("rnd%0d_good", r), N_PIX, d0, e0, 1, 0);
            end else if (kind == 1) begin
                send_frame(cs ^ 8'(1 << $urandom_range(0, 7)), -1, 1'b1);
                check_frame($sformatf("rnd%0d_badcs", r), N_PIX, d0, e0, 0, 1);
            end else begin
                send_frame(cs, pos, 1'b1);
                check_frame($sformatf("rnd%0d_rxerr", r), pos, d0, e0, 0, 1);
            end
        end

        chk("pulse_exclusive", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
